// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl
// Phase sequencer for a two-road intersection (NS main road, EW side road).
// Steps through the signal phases on prescaled ticks, latches side-road and
// pedestrian requests, and drives the lamp register bank through a 6-bit
// pattern bus plus load/enable/clear strobes.
//
// Build option: TRAFFIC_PED_EN
//   defined   - pedestrian request latch and PED_WALK phase are present
//   undefined - ped_req ignored, PED_WALK unreachable, walk tied low
//
// Ports:
//   Clk       in   clock, rising edge
//   Clear_n   in   asynchronous active-low reset
//   tick      in   one-cycle timing pulse from the prescaler
//   car_ew    in   EW vehicle sensor (level)
//   ped_req   in   pedestrian button (level)
//   lamp      out  {ns_r,ns_y,ns_g,ew_r,ew_y,ew_g} to the register bank
//   reg_load  out  bank load strobe, first cycle of every state
//   reg_en    out  bank enable strobe, same timing as reg_load
//   reg_clear out  bank clear strobe, high while in reset
//   phase     out  current state code
//   walk      out  pedestrian walk lamp
//
// state      | meaning
// NS_GREEN   | main road green, holds until a request is latched
// NS_YELLOW  | main road yellow
// ALL_RED_1  | clearance after NS, decides EW or pedestrian service
// EW_GREEN   | side road green, fixed length
// EW_YELLOW  | side road yellow
// ALL_RED_2  | clearance after EW (also the reset state)
// PED_WALK   | all vehicles red, walk lamp on
module traffic_phase_ctrl #(
  parameter int GREEN_TICKS  = 20,
  parameter int YELLOW_TICKS = 4,
  parameter int ALLRED_TICKS = 2,
  parameter int PED_TICKS    = 10,
  parameter int TW           = 8
) (
  input  logic       Clk,
  input  logic       Clear_n,
  input  logic       tick,
  input  logic       car_ew,
  input  logic       ped_req,
  output logic [5:0] lamp,
  output logic       reg_load,
  output logic       reg_en,
  output logic       reg_clear,
  output logic [2:0] phase,
  output logic       walk
);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED_1 = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED_2 = 3'd5,
    PED_WALK  = 3'd6
  } state_t;

  localparam logic [TW-1:0] GREEN_LAST  = TW'(GREEN_TICKS - 1);
  localparam logic [TW-1:0] YELLOW_LAST = TW'(YELLOW_TICKS - 1);
  localparam logic [TW-1:0] ALLRED_LAST = TW'(ALLRED_TICKS - 1);
  localparam logic [TW-1:0] PED_LAST    = TW'(PED_TICKS - 1);

  localparam logic [5:0] LAMP_NS_G = 6'b001100;
  localparam logic [5:0] LAMP_NS_Y = 6'b010100;
  localparam logic [5:0] LAMP_EW_G = 6'b100001;
  localparam logic [5:0] LAMP_EW_Y = 6'b100010;
  localparam logic [5:0] LAMP_RED  = 6'b100100;

  state_t        r_state;
  state_t        w_next;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer_next;
  logic [TW-1:0] w_last;
  logic          w_at_last;
  logic          w_expire;
  logic          w_entering;
  logic          r_ew_pend;
  logic          w_ew_next;
  logic          w_ped_pend;
  logic [5:0]    r_lamp;
  logic [5:0]    w_lamp_next;
  logic          r_load;
  logic          r_clear;
  logic          r_init;

  always_comb begin
    w_last = ALLRED_LAST;
    case (r_state)
      NS_GREEN:  w_last = GREEN_LAST;
      NS_YELLOW: w_last = YELLOW_LAST;
      ALL_RED_1: w_last = ALLRED_LAST;
      EW_GREEN:  w_last = GREEN_LAST;
      EW_YELLOW: w_last = YELLOW_LAST;
      ALL_RED_2: w_last = ALLRED_LAST;
      PED_WALK:  w_last = PED_LAST;
      default:   w_last = ALLRED_LAST;
    endcase
  end

  assign w_at_last = (r_timer == w_last);
  assign w_expire  = tick && w_at_last;

  // Decisions use only the registered request latches, so a request arriving
  // on the expiry edge is left for the next decision.
  always_comb begin
    w_next = r_state;
    case (r_state)
      NS_GREEN:  if (w_expire && (r_ew_pend || w_ped_pend)) w_next = NS_YELLOW;
      NS_YELLOW: if (w_expire) w_next = ALL_RED_1;
      ALL_RED_1: begin
        if (w_expire) begin
          if (r_ew_pend) begin
            w_next = EW_GREEN;
          end else begin
`ifdef TRAFFIC_PED_EN
            w_next = PED_WALK;
`else
            w_next = NS_GREEN;
`endif
          end
        end
      end
      EW_GREEN:  if (w_expire) w_next = EW_YELLOW;
      EW_YELLOW: if (w_expire) w_next = ALL_RED_2;
      ALL_RED_2: begin
        if (w_expire) begin
          if (w_ped_pend) w_next = PED_WALK;
          else            w_next = NS_GREEN;
        end
      end
      PED_WALK:  if (w_expire) w_next = NS_GREEN;
      default:   w_next = ALL_RED_2;
    endcase
  end

  assign w_entering = (w_next != r_state);

  // Only NS_GREEN can sit at its last count with tick high, which gives the
  // saturating hold while no request is pending.
  always_comb begin
    w_timer_next = r_timer;
    if (w_entering)
      w_timer_next = '0;
    else if (tick && !w_at_last)
      w_timer_next = r_timer + TW'(1);
  end

  always_comb begin
    w_ew_next = r_ew_pend;
    if (car_ew && (r_state != EW_GREEN)) w_ew_next = 1'b1;
    if (w_entering && (w_next == EW_GREEN)) w_ew_next = 1'b0;
  end

  always_comb begin
    w_lamp_next = LAMP_RED;
    case (w_next)
      NS_GREEN:  w_lamp_next = LAMP_NS_G;
      NS_YELLOW: w_lamp_next = LAMP_NS_Y;
      EW_GREEN:  w_lamp_next = LAMP_EW_G;
      EW_YELLOW: w_lamp_next = LAMP_EW_Y;
      default:   w_lamp_next = LAMP_RED;
    endcase
  end

  always_ff @(posedge Clk or negedge Clear_n) begin
    if (!Clear_n) begin
      r_state <= ALL_RED_2;
      r_timer <= '0;
    end else begin
      r_state <= w_next;
      r_timer <= w_timer_next;
    end
  end

  // r_init makes the first edge after reset look like entry into ALL_RED_2,
  // so the bank is loaded with the all-red pattern once.
  always_ff @(posedge Clk or negedge Clear_n) begin
    if (!Clear_n) begin
      r_ew_pend <= 1'b0;
      r_lamp    <= LAMP_RED;
      r_load    <= 1'b0;
      r_clear   <= 1'b1;
      r_init    <= 1'b1;
    end else begin
      r_ew_pend <= w_ew_next;
      r_lamp    <= w_lamp_next;
      r_load    <= w_entering || r_init;
      r_clear   <= 1'b0;
      r_init    <= 1'b0;
    end
  end

`ifdef TRAFFIC_PED_EN
  logic r_ped_pend;
  logic w_ped_next;
  logic r_walk;

  always_comb begin
    w_ped_next = r_ped_pend;
    if (ped_req && (r_state != PED_WALK)) w_ped_next = 1'b1;
    if (w_entering && (w_next == PED_WALK)) w_ped_next = 1'b0;
  end

  always_ff @(posedge Clk or negedge Clear_n) begin
    if (!Clear_n) begin
      r_ped_pend <= 1'b0;
      r_walk     <= 1'b0;
    end else begin
      r_ped_pend <= w_ped_next;
      r_walk     <= (w_next == PED_WALK);
    end
  end

  assign w_ped_pend = r_ped_pend;
  assign walk       = r_walk;
`else
  logic w_ped_unused;
  assign w_ped_unused = ped_req;
  assign w_ped_pend   = 1'b0;
  assign walk         = 1'b0;
`endif

  assign lamp      = r_lamp;
  assign reg_load  = r_load;
  assign reg_en    = r_load;
  assign reg_clear = r_clear;
  assign phase     = r_state;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Testbench for traffic_phase_ctrl. Honours TRAFFIC_PED_EN the same way as
// the design. Reference model tracks the phase number, ticks seen in the
// phase and the two request flags; the lamp pattern comes from a lookup.
module tb_traffic_phase_ctrl;
  localparam int G  = 3;
  localparam int Y  = 2;
  localparam int AR = 1;
  localparam int PW = 2;
`ifdef TRAFFIC_PED_EN
  localparam bit PED_EN = 1'b1;
`else
  localparam bit PED_EN = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Clear_n = 1'b0;
  logic       tick = 1'b0;
  logic       car_ew = 1'b0;
  logic       ped_req = 1'b0;
  logic [5:0] lamp;
  logic       reg_load, reg_en, reg_clear, walk;
  logic [2:0] phase;

  traffic_phase_ctrl #(
    .GREEN_TICKS(G), .YELLOW_TICKS(Y), .ALLRED_TICKS(AR), .PED_TICKS(PW), .TW(8)
  ) dut (
    .Clk(Clk), .Clear_n(Clear_n), .tick(tick), .car_ew(car_ew), .ped_req(ped_req),
    .lamp(lamp), .reg_load(reg_load), .reg_en(reg_en), .reg_clear(reg_clear),
    .phase(phase), .walk(walk)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_phase = 5;
  int m_ticks = 0;
  bit m_ew = 0, m_ped = 0, m_first = 1, m_load = 0, m_clear = 1;

  function automatic int plen(input int p);
    case (p)
      0, 3:    return G;
      1, 4:    return Y;
      6:       return PW;
      default: return AR;
    endcase
  endfunction

  function automatic int plamp(input int p);
    case (p)
      0:       return 6'b001100;
      1:       return 6'b010100;
      3:       return 6'b100001;
      4:       return 6'b100010;
      default: return 6'b100100;
    endcase
  endfunction

  always @(posedge Clk or negedge Clear_n) begin
    if (!Clear_n) begin
      m_phase = 5; m_ticks = 0; m_ew = 0; m_ped = 0;
      m_first = 1; m_load = 0; m_clear = 1;
    end else begin
      int nxt;
      nxt = m_phase;
      if (tick && (m_ticks >= plen(m_phase) - 1)) begin
        case (m_phase)
          0: if (m_ew || m_ped) nxt = 1;
          1: nxt = 2;
          2: nxt = m_ew ? 3 : (PED_EN ? 6 : 0);
          3: nxt = 4;
          4: nxt = 5;
          5: nxt = m_ped ? 6 : 0;
          default: nxt = 0;
        endcase
      end
      if (car_ew && m_phase != 3) m_ew = 1;
      if (nxt == 3 && m_phase != 3) m_ew = 0;
      if (PED_EN && ped_req && m_phase != 6) m_ped = 1;
      if (nxt == 6 && m_phase != 6) m_ped = 0;
      m_load  = (nxt != m_phase) || m_first;
      m_ticks = (nxt != m_phase) ? 0 : m_ticks + int'(tick);
      m_first = 0;
      m_clear = 0;
      m_phase = nxt;
    end
  end

  always @(negedge Clk) begin
    chk("phase", int'(phase), m_phase);
    chk("lamp", int'(lamp), plamp(m_phase));
    chk("walk", int'(walk), int'(m_phase == 6));
    chk("reg_load", int'(reg_load), int'(m_load));
    chk("reg_en", int'(reg_en), int'(m_load));
    chk("reg_clear", int'(reg_clear), int'(m_clear));
  end

  // ---------------- directed helpers ----------------
  int tcnt = 0;
  int cnt = 0, loads = 0, walks = 0;
  int seq_p[$];
  int seq_d[$];

  task automatic dcyc(input bit c, input bit p);
    tick = (tcnt % 4 == 3);
    tcnt++;
    car_ew = c;
    ped_req = p;
    @(posedge Clk);
    #1;
  endtask

  task automatic trace_cyc(input bit c, input bit p);
    int pre;
    pre = int'(phase);
    dcyc(c, p);
    if (tick) cnt++;
    if (reg_load) loads++;
    if (walk) walks++;
    if (int'(phase) != pre) begin
      seq_p.push_back(pre);
      seq_d.push_back(cnt);
      cnt = 0;
    end
  endtask

  task automatic trace_start();
    cnt = 0; loads = 0; walks = 0;
    seq_p.delete();
    seq_d.delete();
  endtask

  task automatic trace_until(input int n);
    int k;
    k = 0;
    while (seq_p.size() < n && k < 300) begin
      trace_cyc(0, 0);
      k++;
    end
    chk("trace_len", seq_p.size(), n);
  endtask

  initial begin
    int exp_p[7];
    int exp_d[7];
    int bad;
    int rst_cnt;
    exp_p = '{0, 1, 2, 3, 4, 5, 6};
    exp_d = '{3, 2, 1, 3, 2, 1, 2};

    // Scenario 1: reset and first edges
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_phase", int'(phase), 5);
    chk("rst_lamp", int'(lamp), 6'b100100);
    chk("rst_clear", int'(reg_clear), 1);
    chk("rst_load", int'(reg_load), 0);
    chk("rst_walk", int'(walk), 0);
    Clear_n = 1'b1;
    tcnt = 0;
    dcyc(0, 0);
    chk("first_clear", int'(reg_clear), 0);
    chk("first_load", int'(reg_load), 1);
    chk("first_en", int'(reg_en), 1);
    chk("first_lamp", int'(lamp), 6'b100100);
    dcyc(0, 0);
    chk("second_load", int'(reg_load), 0);
    dcyc(0, 0);
    dcyc(0, 0);
    chk("nsg_phase", int'(phase), 0);
    chk("nsg_lamp", int'(lamp), 6'b001100);
    chk("nsg_load", int'(reg_load), 1);

    // Scenario 3: single car pulse, full EW cycle
    trace_start();
    trace_cyc(1, 0);
    trace_until(6);
    for (int i = 0; i < 6 && i < seq_p.size(); i++) begin
      chk("ew_seq_phase", seq_p[i], exp_p[i]);
      chk("ew_seq_dwell", seq_d[i], exp_d[i]);
    end
    chk("ew_seq_loads", loads, 6);
    chk("ew_end_phase", int'(phase), 0);

    // Scenario 2: no requests, NS green holds (also shows ew_pend was cleared)
    loads = 0;
    bad = 0;
    repeat (80) begin
      dcyc(0, 0);
      if (reg_load) loads++;
      if (phase != 3'd0) bad++;
    end
    chk("hold_loads", loads, 0);
    chk("hold_not_ns", bad, 0);

`ifdef TRAFFIC_PED_EN
    // Scenario 4: car and pedestrian together, EW first then walk
    trace_start();
    trace_cyc(1, 1);
    trace_until(7);
    for (int i = 1; i < 7 && i < seq_p.size(); i++) begin
      chk("both_seq_phase", seq_p[i], exp_p[i]);
      chk("both_seq_dwell", seq_d[i], exp_d[i]);
    end
    chk("both_walk_cycles", walks, 2 * 4);
    chk("both_end_phase", int'(phase), 0);
`else
    // Scenario 5: pedestrian button ignored
    bad = 0;
    walks = 0;
    dcyc(0, 1);
    repeat (80) begin
      dcyc(0, 0);
      if (phase != 3'd0) bad++;
      if (walk) walks++;
    end
    chk("noped_not_ns", bad, 0);
    chk("noped_walk", walks, 0);
`endif

    // Scenario 6: reset in the middle of EW green
    dcyc(1, 0);
    bad = 0;
    while (phase != 3'd3 && bad < 200) begin
      dcyc(0, 0);
      bad++;
    end
    chk("reach_ewg", int'(phase), 3);
    dcyc(0, 1);
    dcyc(0, 0);
    #1;
    Clear_n = 1'b0;
    #1;
    chk("async_phase", int'(phase), 5);
    chk("async_lamp", int'(lamp), 6'b100100);
    chk("async_clear", int'(reg_clear), 1);
    chk("async_load", int'(reg_load), 0);
    @(posedge Clk);
    #1;
    Clear_n = 1'b1;
    tcnt = 0;
    dcyc(0, 0);
    chk("rel_load", int'(reg_load), 1);
    chk("rel_clear", int'(reg_clear), 0);
    repeat (3) dcyc(0, 0);
    chk("rel_phase", int'(phase), 0);
    bad = 0;
    repeat (80) begin
      dcyc(0, 0);
      if (phase != 3'd0) bad++;
    end
    chk("rel_no_service", bad, 0);

    // Randomized run; the compare process checks every cycle
    rst_cnt = 0;
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 9);
      tick = (r < 3) || (n % 200 < 12);
      car_ew = ($urandom_range(0, 29) == 0);
      ped_req = ($urandom_range(0, 29) == 0);
      if (rst_cnt > 0) begin
        rst_cnt--;
        if (rst_cnt == 0) Clear_n = 1'b1;
      end else if ($urandom_range(0, 599) == 0) begin
        #2;
        Clear_n = 1'b0;
        rst_cnt = 2;
      end
      @(posedge Clk);
      #1;
    end
    Clear_n = 1'b1;
    repeat (2) @(posedge Clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/traffic_phase_ctrl.md
# traffic_phase_ctrl

- Sequencer for the two-road intersection (NS main road, EW side road).
- Steps through the signal phases using a prescaled tick and latches side-road and pedestrian requests.
- Drives the lamp-state register bank (the `Dflipflop` instances) through a 6-bit pattern bus plus load/enable/clear strobes.
- Sits between the tick prescaler and the lamp register bank.

## Interface

Parameters:
- GREEN_TICKS, 20, minimum NS green and fixed EW green length in ticks (≥1)
- YELLOW_TICKS, 4, yellow length in ticks (≥1)
- ALLRED_TICKS, 2, all-red clearance length in ticks (≥1)
- PED_TICKS, 10, pedestrian walk length in ticks (≥1)
- TW, 8, timer width; every *_TICKS value is < 2^TW

Ports:
- Clk  in  1  single clock, rising edge
- Clear_n  in  1  asynchronous active-low reset
- tick  in  1  one-cycle timing pulse from prescaler
- car_ew  in  1  EW vehicle sensor, level
- ped_req  in  1  pedestrian button, level
- lamp  out  6  pattern {ns_r,ns_y,ns_g,ew_r,ew_y,ew_g} to register bank `in` pins
- reg_load  out  1  bank load strobe
- reg_en  out  1  bank enable strobe
- reg_clear  out  1  bank clear strobe
- phase  out  3  current state code
- walk  out  1  pedestrian walk lamp

## Operation

State codes:
- 0 NS_GREEN
- 1 NS_YELLOW
- 2 ALL_RED_1
- 3 EW_GREEN
- 4 EW_YELLOW
- 5 ALL_RED_2
- 6 PED_WALK

Lamp patterns:
- NS_GREEN 001100
- NS_YELLOW 010100
- EW_GREEN 100001
- EW_YELLOW 100010
- ALL_RED_1, ALL_RED_2, PED_WALK 100100
- walk=1 only in PED_WALK.

Request latches:
- ew_pend is set by car_ew=1 in any state except EW_GREEN, and cleared on entry to EW_GREEN.
- ped_pend is set by ped_req=1 in any state except PED_WALK, and cleared on entry to PED_WALK.

Timer:
- Cleared on every state entry.
- Increments on each tick while in a state.
- A state "expires" at the clock edge where tick=1 and timer == its length−1.

Transitions (taken on expiry only):
- NS_GREEN → NS_YELLOW: requires (ew_pend|ped_pend). Without a request, NS_GREEN holds indefinitely and the timer saturates at GREEN_TICKS−1.
- NS_YELLOW → ALL_RED_1.
- ALL_RED_1 → EW_GREEN if ew_pend, else PED_WALK.
- EW_GREEN → EW_YELLOW (fixed length; no extension).
- EW_YELLOW → ALL_RED_2.
- ALL_RED_2 → PED_WALK if ped_pend, else NS_GREEN.
- PED_WALK → NS_GREEN.

Priority and late requests:
- When both requests are pending in ALL_RED_1, EW is served first; pedestrian is served after ALL_RED_2.
- A request that rises at the same edge as the expiry of the deciding state is not seen by that decision. It stays latched for the next cycle.

## Timing

Reset values (Clear_n=0, asynchronous):
- phase=5 (ALL_RED_2)
- lamp=100100
- reg_clear=1
- reg_load=0, reg_en=0, walk=0
- timer=0, ew_pend=0, ped_pend=0

First Clk edge after release:
- reg_clear→0.
- reg_load=reg_en=1 for exactly one cycle, with lamp=100100.

Phase changes:
- phase, lamp and walk are registered and change on the same edge as the state.
- reg_load=reg_en=1 for exactly the first cycle of each new state; 0 otherwise.
- The bank captures lamp on the following edge.

Other rules:
- Reset mid-phase immediately forces the reset values; latched requests are lost.
- tick held high counts once per cycle.

## Configuration

TRAFFIC_PED_EN:
- Defined: ped_req latch and PED_WALK state are compiled in as described above.
- Undefined: ped_req is ignored, ped_pend is constant 0, and PED_WALK is unreachable. NS_GREEN exits only on ew_pend; walk is tied 0. The ports remain present.

## Test plan

All scenarios use GREEN_TICKS=3, YELLOW_TICKS=2, ALLRED_TICKS=1, PED_TICKS=2, tick every 4 cycles.

1. Reset release → reg_clear 1→0 and a single reg_load/reg_en pulse with lamp=100100. After 1 tick, phase=0 and lamp=001100.
2. No requests for 20 ticks → phase stays 0, and reg_load pulses only once (on NS_GREEN entry).
3. car_ew one-cycle pulse during NS_GREEN → sequence 0→1→2→3→4→5→0 with dwell 3,2,1,3,2,1 ticks. Exactly one reg_load pulse per transition; ew_pend=0 after EW_GREEN entry.
4. ped_req and car_ew both pulsed in NS_GREEN (TRAFFIC_PED_EN defined) → 0,1,2,3,4,5,6,0. walk=1 only for the 2 ticks of phase 6.
5. ped_req only, TRAFFIC_PED_EN undefined → phase stays 0 and walk=0 throughout.
6. Clear_n dropped mid-EW_GREEN → phase=5, lamp=100100 and reg_clear=1 asynchronously, without waiting for a Clk edge. After release, the sequence restarts as in scenario 1 and EW is not served without a new car_ew.
